// File: rtl/aes_kat_sequencer.sv
// aes_kat_sequencer: runs NUM_VEC known-answer vectors through an external AES core
// and reports pass/fail, failure count, first failing index and core timeouts.
`default_nettype none

module aes_kat_sequencer #(
  parameter int DATA_W  = 128,
  parameter int NUM_VEC = 4,
  parameter int TIMEOUT = 64,
  parameter int IDX_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  output logic [IDX_W-1:0]  vec_idx,
  input  logic [DATA_W-1:0] vec_key,
  input  logic [DATA_W-1:0] vec_pt,
  input  logic [DATA_W-1:0] vec_ct,
  output logic              core_start,
  output logic              core_dec,
  output logic [DATA_W-1:0] core_key,
  output logic [DATA_W-1:0] core_din,
  input  logic [DATA_W-1:0] core_dout,
  input  logic              core_done,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W-1:0]  fail_count,
  output logic [IDX_W-1:0]  first_fail,
  output logic              timeout_err
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, FETCH, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, CHECK, FINISH
  } state_t;

  state_t              state, state_nx;
  logic                mode_q;
  logic [DATA_W-1:0]   key_q, pt_q, ct_q, enc_res, dec_res;
  logic [CNT_W-1:0]    wait_cnt;
  logic                in_wait, timed_out, vec_fail;

  // core_done in the same cycle the counter hits TIMEOUT wins over the timeout
  assign in_wait   = (state == ENC_WAIT) || (state == DEC_WAIT);
  assign timed_out = in_wait && !core_done && (wait_cnt == CNT_MAX);
  assign vec_fail  = (enc_res != ct_q) || (!mode_q && (dec_res != pt_q));

  assign core_key  = key_q;
  assign core_din  = core_dec ? ct_q : pt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    core_start = 1'b0;
    core_dec   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = FETCH;
      end
      FETCH:   state_nx = ENC_REQ;
      ENC_REQ: begin
        core_start = 1'b1;
        state_nx   = ENC_WAIT;
      end
      ENC_WAIT: begin
        if (core_done)      state_nx = mode_q ? CHECK : DEC_REQ;
        else if (timed_out) state_nx = FINISH;
      end
      DEC_REQ: begin
        core_start = 1'b1;
        core_dec   = 1'b1;
        state_nx   = DEC_WAIT;
      end
      DEC_WAIT: begin
        core_dec = 1'b1;
        if (core_done)      state_nx = CHECK;
        else if (timed_out) state_nx = FINISH;
      end
      CHECK:   state_nx = (vec_idx < LAST_IDX) ? FETCH : FINISH;
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 1'b0;
      key_q       <= '0;
      pt_q        <= '0;
      ct_q        <= '0;
      enc_res     <= '0;
      dec_res     <= '0;
      wait_cnt    <= '0;
      vec_idx     <= '0;
      fail_count  <= '0;
      first_fail  <= '1;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_q      <= mode;
          fail_count  <= '0;
          timeout_err <= 1'b0;
          pass        <= 1'b0;
          first_fail  <= '1;
          vec_idx     <= '0;
        end
        FETCH: begin
          key_q <= vec_key;
          pt_q  <= vec_pt;
          ct_q  <= vec_ct;
        end
        ENC_REQ, DEC_REQ: wait_cnt <= '0;
        ENC_WAIT, DEC_WAIT: begin
          wait_cnt <= wait_cnt + CNT_ONE;
          if (core_done) begin
            if (state == ENC_WAIT) enc_res <= core_dout;
            else                   dec_res <= core_dout;
          end
          if (timed_out) timeout_err <= 1'b1;
        end
        CHECK: begin
          if (vec_fail) begin
            if (fail_count != '1) fail_count <= fail_count + IDX_ONE;
            if (first_fail == '1) first_fail <= vec_idx;
          end
          if (vec_idx < LAST_IDX) vec_idx <= vec_idx + IDX_ONE;
        end
        FINISH: pass <= (fail_count == '0) && !timeout_err;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_kat_sequencer.sv
// Self-checking bench for aes_kat_sequencer: behavioural core/ROM model, per-cycle
// transaction monitor and directed plus randomized test runs.
`default_nettype none

module tb_aes_kat_sequencer;

  localparam int DW = 128;
  localparam int NV = 4;
  localparam int TO = 64;
  localparam int IW = 8;
  localparam logic [DW-1:0] K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [DW-1:0] P0 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [DW-1:0] C0 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (NUM_VEC = 4) ----------------
  logic          start = 1'b0, mode = 1'b0;
  logic [IW-1:0] vec_idx, fail_count, first_fail;
  logic [DW-1:0] vec_key, vec_pt, vec_ct, core_key, core_din;
  logic [DW-1:0] core_dout = '0;
  logic          core_start, core_dec, core_done, busy, done, pass, timeout_err;
  logic [DW-1:0] rom_key [NV];
  logic [DW-1:0] rom_pt  [NV];
  logic [DW-1:0] rom_ct  [NV];

  assign vec_key = rom_key[vec_idx[1:0]];
  assign vec_pt  = rom_pt[vec_idx[1:0]];
  assign vec_ct  = rom_ct[vec_idx[1:0]];

  aes_kat_sequencer #(.DATA_W(DW), .NUM_VEC(NV), .TIMEOUT(TO), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .vec_idx(vec_idx),
    .vec_key(vec_key), .vec_pt(vec_pt), .vec_ct(vec_ct),
    .core_start(core_start), .core_dec(core_dec), .core_key(core_key), .core_din(core_din),
    .core_dout(core_dout), .core_done(core_done), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail(first_fail), .timeout_err(timeout_err));

  // ---------------- KAT DUT (NUM_VEC = 1) ----------------
  logic          k_start = 1'b0;
  logic          k_mode = 1'b1;
  logic [IW-1:0] k_vec_idx, k_fail_count, k_first_fail;
  logic [DW-1:0] k_core_key, k_core_din;
  logic [DW-1:0] k_core_dout = '0;
  logic          k_core_start, k_core_dec, k_busy, k_done, k_pass, k_timeout_err;
  logic          k_pend = 1'b0, k_core_done = 1'b0;

  aes_kat_sequencer #(.DATA_W(DW), .NUM_VEC(1), .TIMEOUT(TO), .IDX_W(IW)) u_kat (
    .clk(clk), .rst_n(rst_n), .start(k_start), .mode(k_mode), .vec_idx(k_vec_idx),
    .vec_key(K0), .vec_pt(P0), .vec_ct(C0),
    .core_start(k_core_start), .core_dec(k_core_dec), .core_key(k_core_key), .core_din(k_core_din),
    .core_dout(k_core_dout), .core_done(k_core_done), .busy(k_busy), .done(k_done), .pass(k_pass),
    .fail_count(k_fail_count), .first_fail(k_first_fail), .timeout_err(k_timeout_err));

  // Stand-in cipher: invertible mix, with the FIPS-197 example pinned as a literal pair.
  function automatic logic [DW-1:0] fenc(input logic [DW-1:0] k, input logic [DW-1:0] p);
    logic [DW-1:0] x;
    if (k == K0 && p == P0) return C0;
    x = p ^ k;
    return {x[114:0], x[127:115]} + k;
  endfunction

  function automatic logic [DW-1:0] fdec(input logic [DW-1:0] k, input logic [DW-1:0] c);
    logic [DW-1:0] x;
    if (k == K0 && c == C0) return P0;
    x = c - k;
    x = {x[12:0], x[127:13]};
    return x ^ k;
  endfunction

  // ---------------- core models ----------------
  int            lat = 2;
  bit            hang = 1'b0;
  bit            corrupt_en = 1'b0;
  logic [DW-1:0] corrupt_key = '0;
  logic          model_done = 1'b0, inject = 1'b0;
  int            rem = 0;
  logic [DW-1:0] res;

  assign core_done = model_done | inject;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (core_start && !hang) begin
      res = core_dec ? fdec(core_key, core_din) : fenc(core_key, core_din);
      if (!core_dec && corrupt_en && core_key == corrupt_key) res = res ^ 128'h1;
      rem = lat;
    end
    if (rem > 0) begin
      rem = rem - 1;
      if (rem == 0) begin
        model_done <= 1'b1;
        core_dout  <= res;
      end
    end
  end

  always @(posedge clk) begin
    k_pend      <= k_core_start;
    k_core_done <= k_pend;
    if (k_pend) k_core_dout <= fenc(k_core_key, k_core_din);
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  bit            q_dec [$];
  logic [DW-1:0] q_key [$];
  logic [DW-1:0] q_din [$];
  bit            outstanding = 1'b0;
  bit            expect_done = 1'b0;
  logic          exp_dec;
  logic [DW-1:0] exp_key, exp_din;
  int            exp_fail, exp_first;

  // Every core request must match the next expected transaction; operands hold until done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_start) begin
        if (q_dec.size() == 0) check("core_start_unexpected", core_start, 0);
        else begin
          exp_dec = q_dec.pop_front();
          exp_key = q_key.pop_front();
          exp_din = q_din.pop_front();
          check("req_dec", core_dec, exp_dec);
          check("req_key", core_key, exp_key);
          check("req_din", core_din, exp_din);
          outstanding = 1'b1;
        end
      end else if (outstanding) begin
        check("hold_dec", core_dec, exp_dec);
        check("hold_key", core_key, exp_key);
        check("hold_din", core_din, exp_din);
      end
      if (core_done) outstanding = 1'b0;
      if (done && !expect_done) check("done_spurious", done, 0);
    end
  end

  // Expected transactions and verdict of a complete run, from the ROM contents.
  task automatic build_expect(input bit m);
    logic [DW-1:0] eo;
    bit            f;
    q_dec.delete(); q_key.delete(); q_din.delete();
    outstanding = 1'b0;
    exp_fail  = 0;
    exp_first = 255;
    for (int i = 0; i < NV; i++) begin
      q_dec.push_back(1'b0); q_key.push_back(rom_key[i]); q_din.push_back(rom_pt[i]);
      if (!m) begin
        q_dec.push_back(1'b1); q_key.push_back(rom_key[i]); q_din.push_back(rom_ct[i]);
      end
      eo = fenc(rom_key[i], rom_pt[i]);
      if (corrupt_en && rom_key[i] == corrupt_key) eo = eo ^ 128'h1;
      f = (eo != rom_ct[i]) || (!m && fdec(rom_key[i], rom_ct[i]) != rom_pt[i]);
      if (f) begin
        exp_fail++;
        if (exp_first == 255) exp_first = i;
      end
    end
  endtask

  task automatic run(input bit m, input bit to_exp, input bit extra_start, output int cyc);
    int exp_lat;
    build_expect(m);
    if (to_exp) begin
      q_dec.delete(); q_key.delete(); q_din.delete();
      q_dec.push_back(1'b0); q_key.push_back(rom_key[0]); q_din.push_back(rom_pt[0]);
      exp_fail  = 0;
      exp_first = 255;
      exp_lat   = 3 + TO + 1;
    end else begin
      exp_lat = 1 + NV * (m ? (3 + lat) : (4 + 2 * lat));
    end
    @(negedge clk); mode = m; start = 1'b1;
    @(negedge clk); start = 1'b0;
    expect_done = 1'b1;
    check("busy_after_start", busy, 1);
    cyc = 1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = extra_start && (cyc == 5);
    end
    start = 1'b0;
    check("latency", cyc, exp_lat);
    check("fail_count", fail_count, exp_fail);
    check("first_fail", first_fail, exp_first);
    check("timeout_err", timeout_err, to_exp);
    check("vec_idx_end", vec_idx, to_exp ? 0 : NV - 1);
    @(negedge clk);
    expect_done = 1'b0;
    check("done_one_cycle", done, 0);
    check("busy_end", busy, 0);
    check("pass", pass, (exp_fail == 0) && !to_exp);
    check("txn_left", q_dec.size(), 0);
  endtask

  task automatic check_reset_values();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_core_start", core_start, 0);
    check("rst_pass", pass, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_vec_idx", vec_idx, 0);
    check("rst_fail_count", fail_count, 0);
    check("rst_first_fail", first_fail, 8'hFF);
  endtask

  task automatic rand_rom(input bit allow_bad);
    for (int i = 0; i < NV; i++) begin
      rom_key[i] = {$urandom, $urandom, $urandom, $urandom};
      rom_pt[i]  = {$urandom, $urandom, $urandom, $urandom};
      rom_ct[i]  = fenc(rom_key[i], rom_pt[i]);
      if (allow_bad && $urandom_range(0, 3) == 0)
        rom_ct[i] = rom_ct[i] ^ (128'h1 << $urandom_range(0, 127));
    end
  endtask

  initial begin
    int cyc;
    int last_fail;
    rand_rom(1'b0);
    rom_key[0] = K0; rom_pt[0] = P0; rom_ct[0] = C0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // single-vector FIPS-197 known answer, encrypt-only
    @(negedge clk); k_start = 1'b1;
    @(negedge clk); k_start = 1'b0;
    cyc = 1;
    while (!k_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (k_core_start) check("kat_core_dec", k_core_dec, 0);
    end
    check("kat_latency", cyc, 6);
    check("kat_vec_idx", k_vec_idx, 0);
    @(negedge clk);
    check("kat_pass", k_pass, 1);
    check("kat_fail_count", k_fail_count, 0);
    check("kat_first_fail", k_first_fail, 8'hFF);
    check("kat_timeout", k_timeout_err, 0);
    check("kat_busy", k_busy, 0);

    // directed: encrypt-only, round-trip, corrupted vector 2
    lat = 2;
    run(1'b1, 1'b0, 1'b0, cyc);
    check("lat_mode1_lit", cyc, 21);
    run(1'b0, 1'b0, 1'b1, cyc);
    check("lat_mode0_lit", cyc, 33);
    check("pass_mode0_lit", pass, 1);
    corrupt_en = 1'b1; corrupt_key = rom_key[2];
    run(1'b0, 1'b0, 1'b0, cyc);
    check("corrupt_fail_lit", fail_count, 1);
    check("corrupt_first_lit", first_fail, 2);
    check("corrupt_pass_lit", pass, 0);
    corrupt_en = 1'b0;

    // completion exactly at the timeout count, then one cycle too late, then never
    lat = TO + 1;
    run(1'b1, 1'b0, 1'b0, cyc);
    lat = TO + 2;
    run(1'b1, 1'b1, 1'b0, cyc);
    check("timeout_lat_lit", cyc, 68);
    hang = 1'b1;
    run(1'b0, 1'b1, 1'b0, cyc);
    hang = 1'b0;
    repeat (80) @(negedge clk);

    // stray core_done while idle
    lat = 1;
    run(1'b1, 1'b0, 1'b0, cyc);
    last_fail = exp_fail;
    @(negedge clk); inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_busy", busy, 0);
    check("stray_fail_count", fail_count, last_fail);
    check("stray_pass", pass, 1);

    // reset in the middle of a decrypt wait
    lat = 4;
    build_expect(1'b0);
    @(negedge clk); mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(core_dec && !core_start && busy) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_dec_wait", core_dec && !core_start && busy, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    q_dec.delete(); q_key.delete(); q_din.delete();
    outstanding = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run(1'b0, 1'b0, 1'b0, cyc);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      rand_rom(1'b1);
      lat = $urandom_range(1, 6);
      corrupt_en  = ($urandom_range(0, 2) == 0);
      corrupt_key = rom_key[$urandom_range(0, NV - 1)];
      run(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_kat_sequencer.md
AES_KAT_SEQUENCER -- requirements
Module: aes_kat_sequencer

Interface
REQ-001 Parameter DATA_W, default 128, block and key width in bits.
REQ-002 Parameter NUM_VEC, default 4, number of known-answer vectors run per test (1..256).
REQ-003 Parameter TIMEOUT, default 64, maximum cycles to wait for core_done per core operation.
REQ-004 Parameter IDX_W, default 8, width of vector index and fail counters.
REQ-005 Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a test run when idle.
- mode  in  1  0 = round-trip (encrypt, decrypt, compare with plaintext); 1 = encrypt-only (compare with expected ciphertext).
- vec_idx  out  IDX_W  index presented to the external vector ROM.
- vec_key, vec_pt, vec_ct  in  DATA_W each  ROM key, plaintext, expected ciphertext; valid in the cycle after vec_idx changes.
- core_start  out  1  one-cycle request to the AES core.
- core_dec  out  1  0 = encrypt, 1 = decrypt; held stable while a core operation is outstanding.
- core_key, core_din  out  DATA_W each  operands; held stable while a core operation is outstanding.
- core_dout  in  DATA_W  core result, valid while core_done = 1.
- core_done  in  1  core completion pulse.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse at run end.
- pass  out  1  sticky; 1 if the last run had zero failures and no timeout.
- fail_count  out  IDX_W  mismatching vectors in the last run, saturating.
- first_fail  out  IDX_W  index of the first failing vector; all-ones if none.
- timeout_err  out  1  sticky; the last run was aborted on a core timeout.

Function
REQ-006 The FSM SHALL use states IDLE, FETCH, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, CHECK, FINISH.
REQ-007 IDLE: start = 1 SHALL latch mode, clear fail_count, timeout_err and pass, set first_fail to all-ones, set vec_idx to 0, and go to FETCH; start outside IDLE SHALL be ignored.
REQ-008 FETCH SHALL last exactly one cycle, capture vec_key, vec_pt and vec_ct into internal registers, then go to ENC_REQ.
REQ-009 ENC_REQ SHALL assert core_start for one cycle with core_dec = 0, core_key = the key and core_din = the plaintext, then go to ENC_WAIT.
REQ-010 ENC_WAIT SHALL capture core_dout into the result register on core_done; it then goes to DEC_REQ if the latched mode = 0, otherwise to CHECK.
REQ-011 DEC_REQ and DEC_WAIT SHALL mirror ENC_REQ and ENC_WAIT, using core_dec = 1 and core_din = the captured ciphertext, and then go to CHECK.
REQ-012 In mode 0, CHECK SHALL compare the encrypt result with vec_ct and the decrypt result with vec_pt; in mode 1 it compares only the encrypt result with vec_ct. Any mismatch counts as one failure for that vector.
REQ-013 On a failure, fail_count SHALL increment and saturate at 2^IDX_W-1; first_fail SHALL be written only if it is still all-ones.
REQ-014 After CHECK, the FSM SHALL increment vec_idx and go to FETCH if vec_idx < NUM_VEC-1; otherwise it goes to FINISH.
REQ-015 A wait counter SHALL clear on entry to each WAIT state; if it reaches TIMEOUT without core_done, the FSM sets timeout_err and goes directly to FINISH.
REQ-016 core_done SHALL be ignored outside the WAIT states; core_done arriving in the same cycle the counter reaches TIMEOUT SHALL count as completion, not as a timeout.
REQ-017 FINISH SHALL pulse done for one cycle, set pass = (fail_count == 0) and not timeout_err, and return to IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 Latency per vector in mode 1 SHALL be 3 + core latency cycles; in mode 0 it SHALL be 4 + twice the core latency.

Reset
REQ-020 rst_n = 0 SHALL asynchronously force state IDLE; core_start, busy, done, pass, timeout_err, vec_idx and fail_count to 0; and first_fail to all-ones. This applies mid-run, discards the run, and issues no done pulse.
REQ-021 After rst_n deasserts, the block SHALL accept start no earlier than the first rising clock edge.

Verification
REQ-022 mode = 1 with NUM_VEC = 1, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, ct 3925841d02dc09fbdc118597196a0b32, and a correct core model -> done pulses, pass = 1, fail_count = 0, first_fail = FF.
REQ-023 mode = 0, NUM_VEC = 4, correct core -> exactly 8 core_start pulses with core_dec sequence 0,1,0,1,..., then pass = 1.
REQ-024 Core model corrupts the vector 2 ciphertext -> fail_count = 1, first_fail = 2, pass = 0, and all 4 vectors are run.
REQ-025 Core never asserts core_done, TIMEOUT = 64 -> timeout_err = 1 and done pulses 64 cycles after the first WAIT entry (+1 for FINISH), pass = 0.
REQ-026 rst_n pulsed low during DEC_WAIT -> all outputs return to their reset values at once, no done pulse; a new start then runs from vec_idx 0.
REQ-027 start pulsed while busy, and core_done pulsed while in IDLE -> no effect on the state, counters or core_start.
